// File: rtl/meta_array_pkg.sv
// Shared cache-subsystem types used by the metadata array and its
// flash-invalidate sequencer.
package rv32i_types;

    // Flash-invalidate sequencer states: IDLE accepts accesses, CLEAR walks sets.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } meta_inv_state_t;

endpackage

// File: rtl/meta_array_if.sv
// Access and invalidate bus of the metadata array. The requester drives the
// master side; the array implements the slave side.
interface meta_array_if #(
    parameter int S_INDEX = 4,
    parameter int WAYS    = 4,
    parameter int WIDTH   = 1
) ();

    logic                     csb0;
    logic                     web0;
    logic [S_INDEX-1:0]       addr0;
    logic [WAYS-1:0]          wmask0;
    logic [WAYS*WIDTH-1:0]    din0;
    logic [WAYS*WIDTH-1:0]    dout0;
    logic [WAYS-1:0]          perr0;
    logic                     ready0;
    logic                     inv_req;
    logic [WAYS-1:0]          inv_mask;
    logic                     inv_busy;
    logic                     inv_done;

    modport master (
        output csb0, web0, addr0, wmask0, din0, inv_req, inv_mask,
        input  dout0, perr0, ready0, inv_busy, inv_done
    );

    modport slave (
        input  csb0, web0, addr0, wmask0, din0, inv_req, inv_mask,
        output dout0, perr0, ready0, inv_busy, inv_done
    );

endinterface

// File: rtl/meta_array_inv_seq.sv
// Flash-invalidate sequencer: owns the IDLE/CLEAR FSM, the set walker and
// the latched way mask, and produces the ready/busy/done handshake.
module meta_inv_seq
    import rv32i_types::*;
#(
    parameter int S_INDEX = 4,
    parameter int WAYS    = 4
) (
    input  logic               clk0,
    input  logic               rst0,
    input  logic               inv_req,
    input  logic [WAYS-1:0]    inv_mask,
    output logic               clr_en,
    output logic [S_INDEX-1:0] clr_idx,
    output logic [WAYS-1:0]    clr_mask,
    output logic               ready,
    output logic               inv_busy,
    output logic               inv_done
);

    // The walker stops on a terminal compare against the last set so it can
    // never wrap back to set 0 and keep clearing.
    localparam logic [S_INDEX-1:0] IDX_LAST = '1;
    localparam logic [S_INDEX-1:0] IDX_ONE  = S_INDEX'(1);

    meta_inv_state_t    state_q, state_d;
    logic [S_INDEX-1:0] idx_q, idx_d;
    logic [WAYS-1:0]    mask_q, mask_d;
    logic               done_q, done_d;

    // State, walker index, latched mask and registered done pulse.
    always_ff @(posedge clk0 or negedge rst0) begin
        if (!rst0) begin
            state_q <= IDLE;
            idx_q   <= '0;
            mask_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic plus Moore handshake outputs decoded from the state.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mask_d   = mask_q;
        done_d   = 1'b0;
        clr_en   = 1'b0;
        ready    = 1'b0;
        inv_busy = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (inv_req) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                    mask_d  = inv_mask;
                end
            end
            CLEAR: begin
                clr_en   = 1'b1;
                inv_busy = 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign clr_idx  = idx_q;
    assign clr_mask = mask_q;
    assign inv_done = done_q;

endmodule

// File: rtl/meta_array.sv
// Multi-way per-set metadata store with per-way write mask, write-first read
// and a built-in flash-invalidate walker.
// Optional feature macro: META_ARRAY_PARITY_EN adds one even-parity bit per
// way entry and reports per-way parity mismatches on perr0.
module meta_array
    import rv32i_types::*;
#(
    parameter int S_INDEX = 4,
    parameter int WAYS    = 4,
    parameter int WIDTH   = 1
) (
    input  logic        clk0,
    input  logic        rst0,
    meta_array_if.slave bus
);

    localparam int NUM_SETS = 2 ** S_INDEX;
    localparam int DW       = WAYS * WIDTH;

    logic [DW-1:0]      mem [NUM_SETS];
    logic [DW-1:0]      rd_word;
    logic [DW-1:0]      rd_next;
    logic [DW-1:0]      dout_q;
    logic [WAYS-1:0]    wr_en;
    logic               accept;
    logic               ready;
    logic               clr_en;
    logic [S_INDEX-1:0] clr_idx;
    logic [WAYS-1:0]    clr_mask;

    meta_inv_seq #(
        .S_INDEX (S_INDEX),
        .WAYS    (WAYS)
    ) u_inv_seq (
        .clk0     (clk0),
        .rst0     (rst0),
        .inv_req  (bus.inv_req),
        .inv_mask (bus.inv_mask),
        .clr_en   (clr_en),
        .clr_idx  (clr_idx),
        .clr_mask (clr_mask),
        .ready    (ready),
        .inv_busy (bus.inv_busy),
        .inv_done (bus.inv_done)
    );

    assign bus.ready0 = ready;
    assign accept     = !bus.csb0 && ready;
    assign rd_word    = mem[bus.addr0];

    // Per-way write enables and write-first read data for an accepted access.
    always_comb begin
        wr_en   = '0;
        rd_next = rd_word;
        for (int w = 0; w < WAYS; w++) begin
            wr_en[w] = accept && !bus.web0 && bus.wmask0[w];
            if (wr_en[w]) begin
                rd_next[w*WIDTH +: WIDTH] = bus.din0[w*WIDTH +: WIDTH];
            end
        end
    end

    // Entry storage: cleared by reset, zeroed by the walker, written by accesses.
    always_ff @(posedge clk0 or negedge rst0) begin
        if (!rst0) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                mem[s] <= '0;
            end
        end else if (clr_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (clr_mask[w]) begin
                    mem[clr_idx][w*WIDTH +: WIDTH] <= '0;
                end
            end
        end else begin
            for (int w = 0; w < WAYS; w++) begin
                if (wr_en[w]) begin
                    mem[bus.addr0][w*WIDTH +: WIDTH] <= bus.din0[w*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Read data register: updates only on accepted accesses, holds otherwise.
    always_ff @(posedge clk0 or negedge rst0) begin
        if (!rst0) begin
            dout_q <= '0;
        end else if (accept) begin
            dout_q <= rd_next;
        end
    end

    assign bus.dout0 = dout_q;

`ifdef META_ARRAY_PARITY_EN
    logic [WAYS-1:0] par_mem [NUM_SETS];
    logic [WAYS-1:0] par_rd;
    logic [WAYS-1:0] perr_next;
    logic [WAYS-1:0] perr_q;

    assign par_rd = par_mem[bus.addr0];

    // Parity check of stored ways; bypassed ways never flag.
    always_comb begin
        perr_next = '0;
        for (int w = 0; w < WAYS; w++) begin
            perr_next[w] = !wr_en[w] && ((^rd_word[w*WIDTH +: WIDTH]) != par_rd[w]);
        end
    end

    // Parity storage tracks the entry storage; cleared entries get parity 0.
    always_ff @(posedge clk0 or negedge rst0) begin
        if (!rst0) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                par_mem[s] <= '0;
            end
        end else if (clr_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (clr_mask[w]) begin
                    par_mem[clr_idx][w] <= 1'b0;
                end
            end
        end else begin
            for (int w = 0; w < WAYS; w++) begin
                if (wr_en[w]) begin
                    par_mem[bus.addr0][w] <= ^bus.din0[w*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Parity error register follows the same accept/hold rule as dout0.
    always_ff @(posedge clk0 or negedge rst0) begin
        if (!rst0) begin
            perr_q <= '0;
        end else if (accept) begin
            perr_q <= perr_next;
        end
    end

    assign bus.perr0 = perr_q;
`else
    assign bus.perr0 = '0;
`endif

endmodule

// File: tb/tb_meta_array.sv
// Scoreboard bench for meta_array: stimulus pushes expected read data for each
// access it expects to be accepted; a monitor pops and compares after the edge.
module tb_meta_array;

    localparam int S_INDEX  = 4;
    localparam int WAYS     = 4;
    localparam int WIDTH    = 1;
    localparam int NUM_SETS = 16;

    logic clk0 = 1'b0;
    logic rst0 = 1'b1;

    always #5 clk0 = ~clk0;

    meta_array_if #(.S_INDEX(S_INDEX), .WAYS(WAYS), .WIDTH(WIDTH)) bus ();

    meta_array #(.S_INDEX(S_INDEX), .WAYS(WAYS), .WIDTH(WIDTH)) dut (
        .clk0 (clk0),
        .rst0 (rst0),
        .bus  (bus)
    );

    typedef struct {
        logic [3:0] dout;
        logic [3:0] perr;
        int         id;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passes = 0;
    int   acc_id = 0;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passes++;
        else $display("[TB] FAIL %s: got %0h want %0h", name, got, want);
    endtask

    task automatic applyStimulus(input logic csb, input logic web, input logic [3:0] addr,
                                 input logic [3:0] wmask, input logic [3:0] din,
                                 input logic req, input logic [3:0] mask, input logic expect_acc,
                                 input logic [3:0] exp_dout, input logic [3:0] exp_perr);
        @(negedge clk0);
        bus.csb0     = csb;
        bus.web0     = web;
        bus.addr0    = addr;
        bus.wmask0   = wmask;
        bus.din0     = din;
        bus.inv_req  = req;
        bus.inv_mask = mask;
        if (expect_acc) begin
            sb_q.push_back('{dout: exp_dout, perr: exp_perr, id: acc_id});
            acc_id++;
        end
    endtask

    task automatic access(input logic web, input logic [3:0] addr, input logic [3:0] wmask,
                          input logic [3:0] din, input logic [3:0] exp_dout);
        applyStimulus(1'b0, web, addr, wmask, din, 1'b0, 4'b0000, 1'b1, exp_dout, 4'b0000);
    endtask

    task automatic idle();
        applyStimulus(1'b1, 1'b1, 4'd0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000);
    endtask

    // Monitor: decide acceptance from the settled pre-edge inputs, compare after the edge.
    initial begin : monitor
        exp_t e;
        logic acc;
        forever begin
            @(negedge clk0);
            #1;
            acc = !bus.csb0 && bus.ready0 && rst0;
            @(posedge clk0);
            #1;
            if (acc) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpected_accept: got accept at %0t want none", $time);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput($sformatf("acc%0d_dout", e.id), 32'(bus.dout0), 32'(e.dout));
                    checkOutput($sformatf("acc%0d_perr", e.id), 32'(bus.perr0), 32'(e.perr));
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int busy_cnt, done_cnt, ready_bad, first_busy, done_cyc, busy_seen;

        bus.csb0 = 1'b1; bus.web0 = 1'b1; bus.addr0 = '0; bus.wmask0 = '0;
        bus.din0 = '0; bus.inv_req = 1'b0; bus.inv_mask = '0;

        #2 rst0 = 1'b0;
        #5;
        checkOutput("rst_dout",  32'(bus.dout0),    32'h0);
        checkOutput("rst_perr",  32'(bus.perr0),    32'h0);
        checkOutput("rst_ready", 32'(bus.ready0),   32'h1);
        checkOutput("rst_busy",  32'(bus.inv_busy), 32'h0);
        checkOutput("rst_done",  32'(bus.inv_done), 32'h0);
        @(negedge clk0);
        rst0 = 1'b1;

        access(1'b1, 4'd3, 4'b0000, 4'b0000, 4'b0000);
        access(1'b0, 4'd5, 4'b0101, 4'b1111, 4'b0101);
        access(1'b1, 4'd5, 4'b0000, 4'b0000, 4'b0101);
        access(1'b0, 4'd5, 4'b0001, 4'b0000, 4'b0100);
        access(1'b0, 4'd5, 4'b1110, 4'b1010, 4'b1010);
        access(1'b1, 4'd5, 4'b1111, 4'b0000, 4'b1010);

        for (int s = 0; s < NUM_SETS; s++) access(1'b0, 4'(s), 4'b1111, 4'b1111, 4'b1111);

        // Write to set 2 in the same cycle as the invalidate request.
        applyStimulus(1'b0, 1'b0, 4'd2, 4'b1111, 4'b0110, 1'b1, 4'b0011, 1'b1, 4'b0110, 4'b0000);
        busy_cnt = 0; done_cnt = 0; ready_bad = 0; first_busy = -1; done_cyc = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk0);
            if (cyc == 0) begin
                bus.inv_req = 1'b0; bus.csb0 = 1'b0; bus.web0 = 1'b1; bus.addr0 = 4'd7;
            end
            if (cyc == 3) bus.csb0 = 1'b1;
            if (bus.inv_busy) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = cyc;
                if (bus.ready0) ready_bad++;
            end
            if (bus.inv_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        checkOutput("clr_busy_cycles", 32'(busy_cnt),   32'd16);
        checkOutput("clr_first_busy",  32'(first_busy), 32'd0);
        checkOutput("clr_ready_low",   32'(ready_bad),  32'd0);
        checkOutput("clr_done_pulses", 32'(done_cnt),   32'd1);
        checkOutput("clr_done_cycle",  32'(done_cyc),   32'd16);
        checkOutput("clr_dout_hold",   32'(bus.dout0),  32'h6);

        for (int s = 0; s < NUM_SETS; s++)
            access(1'b1, 4'(s), 4'b0000, 4'b0000, (s == 2) ? 4'b0100 : 4'b1100);

        // Start another walk and pull reset while set 7 is being cleared.
        applyStimulus(1'b1, 1'b1, 4'd0, 4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0000);
        @(negedge clk0);
        bus.inv_req = 1'b0;
        repeat (7) @(negedge clk0);
        checkOutput("mid_busy_at7", 32'(bus.inv_busy), 32'h1);
        #2 rst0 = 1'b0;
        #1;
        checkOutput("mid_rst_ready", 32'(bus.ready0),   32'h1);
        checkOutput("mid_rst_busy",  32'(bus.inv_busy), 32'h0);
        checkOutput("mid_rst_done",  32'(bus.inv_done), 32'h0);
        checkOutput("mid_rst_dout",  32'(bus.dout0),    32'h0);
        @(negedge clk0);
        rst0 = 1'b1;
        done_cnt = 0; busy_seen = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk0);
            if (bus.inv_done) done_cnt++;
            if (bus.inv_busy) busy_seen++;
        end
        checkOutput("mid_no_done", 32'(done_cnt),  32'd0);
        checkOutput("mid_no_busy", 32'(busy_seen), 32'd0);

        for (int s = 0; s < NUM_SETS; s++) access(1'b1, 4'(s), 4'b0000, 4'b0000, 4'b0000);

        access(1'b0, 4'd9, 4'b1111, 4'b1011, 4'b1011);
        access(1'b1, 4'd9, 4'b0000, 4'b0000, 4'b1011);

`ifdef META_ARRAY_PARITY_EN
        access(1'b0, 4'd5, 4'b1111, 4'b0000, 4'b0000);
        idle();
        dut.par_mem[5][1] = 1'b1;
        applyStimulus(1'b0, 1'b1, 4'd5, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0010);
        applyStimulus(1'b0, 1'b0, 4'd5, 4'b0010, 4'b0010, 1'b0, 4'b0000, 1'b1, 4'b0010, 4'b0000);
        applyStimulus(1'b0, 1'b1, 4'd5, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'b0010, 4'b0000);
`endif

        idle();
        repeat (3) @(negedge clk0);
        checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/meta_array.md
# meta_array

Multi-way, per-set metadata store (valid/dirty/LRU-style bits) for the cache subsystem. It generalises the single-bit, single-way valid store to WAYS independent entries per set with a per-way write mask and write-first read. It also has a sequenced flash-invalidate engine for fence/flush, so software-visible invalidation needs no external set walker. It sits beside the tag/data SRAMs and is accessed in the same cycle as them.

## Interface
- S_INDEX, 4, set index width; NUM_SETS = 2**S_INDEX
- WAYS, 4, entries per set (≥1)
- WIDTH, 1, bits per way entry (≥1)
- clk0  in  1  clock, all state on rising edge
- rst0  in  1  reset, asynchronous, active-low
- csb0  in  1  chip select, active-low; access requested when 0
- web0  in  1  write enable, active-low; 1 = read only
- addr0  in  S_INDEX  set index
- wmask0  in  WAYS  per-way write enable, active-high, ignored when web0=1
- din0  in  WAYS*WIDTH  write data, way w at [w*WIDTH +: WIDTH]
- dout0  out  WAYS*WIDTH  registered read data, same packing
- perr0  out  WAYS  registered per-way parity error flag
- ready0  out  1  high when an access can be accepted
- inv_req  in  1  start flash invalidate (level sampled in IDLE)
- inv_mask  in  WAYS  ways cleared by the invalidate, sampled with inv_req
- inv_busy  out  1  invalidate in progress
- inv_done  out  1  one-cycle pulse when invalidate completes

## Operation
- Access accepted on an edge where csb0=0 and ready0=1.
- Accepted access: dout0 <= set contents, with write-first bypass. Ways with web0=0 and wmask0[w]=1 return din0 for way w and store it. Other ways return stored data unchanged.
- csb0=1, or ready0=0 with csb0=0: no state change, dout0/perr0 hold. Requester must retry; no queuing.
- Invalidate FSM, states IDLE, CLEAR:
  - IDLE: ready0=1, inv_busy=0. inv_req=1 latches inv_mask and resets set counter clr_idx to 0, then moves to CLEAR. An access in the same cycle is still accepted and completes before clearing starts.
  - CLEAR: ready0=0, inv_busy=1. Each cycle, masked ways of set clr_idx are zeroed and clr_idx increments. When clr_idx=NUM_SETS-1 is cleared: go to IDLE, inv_done=1 for that following cycle.
  - inv_req is ignored in CLEAR. It is re-sampled in IDLE, so a held-high inv_req restarts the walk after inv_done.
- Invalidate cost: exactly NUM_SETS cycles in CLEAR. clr_idx is S_INDEX+1 bits or uses a terminal compare; it must not wrap silently.
- Reset (asserted at any time, including mid-CLEAR):
  - all entries become 0 immediately;
  - FSM goes to IDLE, clr_idx=0;
  - dout0=0, perr0=0, ready0=1, inv_busy=0, inv_done=0.

## Timing
- Read latency: 1 cycle; dout0 valid from the edge accepting the access until the next accepted access.
- Write visible to a read of the same set on the next accepted access; same-cycle write is bypassed to dout0.
- ready0, inv_busy are Moore outputs of FSM state; inv_done registered.
- Release of rst0 is asynchronous; first access may be accepted on the first edge after release.

## Configuration
- META_ARRAY_PARITY_EN defined:
  - each way stores one extra even-parity bit computed from written data;
  - on read, perr0[w] <= parity mismatch for way w;
  - bypassed ways and cleared entries (all-zero, parity 0) never flag.
- Undefined:
  - no parity storage;
  - perr0 tied to 0;
  - ports unchanged.

## Structure
- Shared package rv32i_types: enum meta_inv_state_t {IDLE, CLEAR}.
- Sub-module meta_inv_seq: FSM, clr_idx counter, inv_mask latch. It outputs clear-enable, clear index and masks to the array core, and the ready0/inv_busy/inv_done handshake.

## Test plan
- Reset then read set 3 -> dout0=0, perr0=0, ready0=1.
- WAYS=4,WIDTH=1: write addr 5 din0=4'b1111 wmask0=4'b0101 -> dout0=4'b0101 next cycle; read addr 5 -> 4'b0101.
- Fill all sets with 4'b1111, inv_req with inv_mask=4'b0011:
  - inv_busy high exactly 16 cycles, ready0 low;
  - inv_done one pulse;
  - every set reads 4'b1100.
- Access with csb0=0 during CLEAR -> not accepted, dout0 unchanged. Same-cycle inv_req plus write to addr 2 in IDLE -> write lands, then cleared if masked.
- rst0 low at clr_idx=7 -> immediate IDLE, array 0, inv_done never pulses.
- META_ARRAY_PARITY_EN: force stored parity bit flip on way 1, read -> perr0=4'b0010; without macro perr0=0.
